// File: rtl/inst_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage.
// Contents: opcode constants, instruction width, the queue entry layout,
// the fetch FSM state encoding and jump predecode helpers.
package inst_fetch_unit_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    // One fetch-queue entry: instruction address in the upper half.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // True when the word is an unconditional J.
    function automatic logic is_jump(input logic [INST_W-1:0] inst);
        return inst[31:26] == OP_J;
    endfunction

    // J target: region bits of PC+4 with the 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0]       pc_plus4,
                                                input logic [INST_W-1:0] inst);
        return {pc_plus4[31:28], inst[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// fetch_queue: QDEPTH-entry synchronous FIFO of {PC, Inst} pairs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, pop    enqueue din / dequeue head (ignored when full / empty)
//   flush        empty the queue; wins over push
//   din          entry to enqueue
//   dout         registered head entry; holds its last value while empty
//   valid        registered "queue not empty"
//   count        number of stored entries
module fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned PTR_W = $clog2(QDEPTH),
    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               valid,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem_q [QDEPTH];
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               do_push;
    logic               do_pop;

    // Next pointers, count and head register.
    always_comb begin
        do_pop  = pop & (count_q != '0);
        do_push = push & ~flush & ((count_q != CNT_W'(QDEPTH)) | do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_d = wr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The new head may be the entry being written this cycle.
            if (count_d != '0) begin
                dout_d = (do_push && (wr_q == rd_d)) ? din : mem_q[rd_d];
            end
        end
        valid_d = (count_d != '0);
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage in front of a combinational instruction ROM.
// Owns the PC, predecodes J for bubble-free jumps, takes branch redirects
// from execute and hands {PC, Inst} pairs to the decoder through a queue.
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Addr              ROM address (current PC)
//   Inst              ROM data for Addr, same cycle
//   Halt              stop issuing fetches; queue keeps draining
//   Redirect_Valid    taken branch; flushes queue, loads Redirect_Target
//   Redirect_Target   new PC
//   Out_Valid         queue head valid
//   Out_Ready         decoder accepts the head this cycle
//   Out_Inst, Out_PC  head instruction and its address
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Halt,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Inst,
    output logic [31:0] Out_PC
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pc_plus4;
    logic               fetch_en;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] q_dout;
    logic               q_valid;
    logic [CNT_W-1:0]   q_count;
    fetch_entry_t       head;

    assign pc_plus4   = pc_q + 32'd4;
    assign pop        = q_valid & Out_Ready;
    assign push_entry = {pc_q, Inst};

    // FSM next state, fetch enable and next-PC mux (redirect > jump > +4 > hold).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fetch_en = 1'b0;
        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (Halt)  state_d = ST_HALTED;
            ST_HALTED: if (!Halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
        // A pop this cycle frees a slot even when the queue is full.
        if ((state_q == ST_RUN) && !Halt && !Redirect_Valid &&
            ((q_count < CNT_W'(QDEPTH)) || pop)) begin
            fetch_en = 1'b1;
        end
        if (Redirect_Valid) begin
            pc_d = Redirect_Target;
        end else if (fetch_en) begin
            pc_d = is_jump(Inst) ? jump_target(pc_plus4, Inst) : pc_plus4;
        end
    end

    // State and PC registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (fetch_en),
        .pop   (pop),
        .flush (Redirect_Valid),
        .din   (push_entry),
        .dout  (q_dout),
        .valid (q_valid),
        .count (q_count)
    );

    assign head      = fetch_entry_t'(q_dout);
    assign Addr      = pc_q;
    assign Out_Valid = q_valid;
    assign Out_Inst  = head.inst;
    assign Out_PC    = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a per-cycle vector table for the
// main stream plus hand-written sequences for the RESET_PC variants.
module tb_inst_fetch_unit;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst_n;
    logic        Halt;
    logic        Rv;
    logic [31:0] Rt;
    logic        Out_Ready;

    logic [31:0] addr0, inst0, oi0, opc0;
    logic        ov0;
    logic [31:0] addr1, inst1, oi1, opc1;
    logic        ov1;
    logic [31:0] addr2, inst2, oi2, opc2;
    logic        ov2;

    int n_chk  = 0;
    int n_fail = 0;

    // ROM: word 0x4C holds J to word index 0xF, everything else is a BEQ tagged with its address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a[9:2] == 8'h13) return 32'h0800_000F;
        return 32'h1000_0000 | {22'b0, a[9:0]};
    endfunction

    assign inst0 = rom(addr0);
    assign inst1 = rom(addr1);
    assign inst2 = rom(addr2);

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Addr(addr0), .Inst(inst0), .Halt(Halt),
        .Redirect_Valid(Rv), .Redirect_Target(Rt), .Out_Valid(ov0),
        .Out_Ready(Out_Ready), .Out_Inst(oi0), .Out_PC(opc0)
    );

    inst_fetch_unit #(.RESET_PC(32'h0000_0004), .QDEPTH(2)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Addr(addr1), .Inst(inst1), .Halt(1'b0),
        .Redirect_Valid(1'b0), .Redirect_Target(32'h0), .Out_Valid(ov1),
        .Out_Ready(1'b1), .Out_Inst(oi1), .Out_PC(opc1)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Addr(addr2), .Inst(inst2), .Halt(1'b0),
        .Redirect_Valid(1'b0), .Redirect_Target(32'h0), .Out_Valid(ov2),
        .Out_Ready(1'b1), .Out_Inst(oi2), .Out_PC(opc2)
    );

    typedef struct {
        bit          rst;
        logic        rdy;
        logic        halt;
        logic        rv;
        logic [31:0] rt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Row with a valid-or-held head whose instruction is the ROM word at epc.
    task automatic add(input bit rst, input logic rdy, input logic halt, input logic rv,
                       input logic [31:0] rt, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.halt = halt; v.rv = rv; v.rt = rt;
        v.ev = ev; v.epc = epc; v.einst = rom(epc); v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    // Row right after reset: head registers still at their reset value.
    task automatic add_boot(input logic rdy, input logic rv, input logic [31:0] rt,
                            input logic [31:0] eaddr);
        vec_t v;
        v.rst = 1'b1; v.rdy = rdy; v.halt = 1'b0; v.rv = rv; v.rt = rt;
        v.ev = 1'b0; v.epc = 32'h0; v.einst = 32'h0; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic apply_reset();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst ov0",   32'(ov0),  32'h0);
        chk("rst addr0", addr0,     32'h0);
        chk("rst opc0",  opc0,      32'h0);
        chk("rst oi0",   oi0,       32'h0);
        chk("rst addr1", addr1,     32'h0000_0004);
        chk("rst addr2", addr2,     32'hFFFF_FFF8);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b1; Halt = 1'b0; Rv = 1'b0; Rt = 32'h0; Out_Ready = 1'b1;

        // Stream with Out_Ready=1, then Halt at PC 0x10.
        add_boot(1'b1, 1'b0, 32'h0, 32'h00);
        add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h04);
        add(0, 1, 0, 0, 32'h0, 1, 32'h04, 32'h08);
        add(0, 1, 0, 0, 32'h0, 1, 32'h08, 32'h0C);
        add(0, 1, 0, 0, 32'h0, 1, 32'h0C, 32'h10);
        add(0, 1, 1, 0, 32'h0, 0, 32'h0C, 32'h10);
        add(0, 1, 1, 0, 32'h0, 0, 32'h0C, 32'h10);
        add(0, 1, 0, 0, 32'h0, 0, 32'h0C, 32'h10);
        add(0, 1, 0, 0, 32'h0, 1, 32'h10, 32'h14);
        add(0, 1, 0, 0, 32'h0, 1, 32'h14, 32'h18);
        // Backpressure for 5 cycles from boot, then redirects and the J at 0x4C.
        add_boot(1'b0, 1'b0, 32'h0, 32'h00);
        add(0, 0, 0, 0, 32'h0, 1, 32'h00, 32'h04);
        add(0, 0, 0, 0, 32'h0, 1, 32'h00, 32'h08);
        add(0, 0, 0, 0, 32'h0, 1, 32'h00, 32'h08);
        add(0, 0, 0, 0, 32'h0, 1, 32'h00, 32'h08);
        add(0, 1, 0, 0, 32'h0, 1, 32'h04, 32'h0C);
        add(0, 1, 0, 0, 32'h0, 1, 32'h08, 32'h10);
        add(0, 1, 0, 0, 32'h0, 1, 32'h0C, 32'h14);
        add(0, 1, 0, 0, 32'h0, 1, 32'h10, 32'h18);
        add(0, 0, 0, 0, 32'h0, 1, 32'h10, 32'h18);
        add(0, 0, 0, 1, 32'h30, 0, 32'h10, 32'h30);
        add(0, 0, 0, 0, 32'h0, 1, 32'h30, 32'h34);
        add(0, 1, 0, 1, 32'h48, 0, 32'h30, 32'h48);
        add(0, 1, 0, 0, 32'h0, 1, 32'h48, 32'h4C);
        add(0, 1, 0, 0, 32'h0, 1, 32'h4C, 32'h3C);
        add(0, 1, 0, 0, 32'h0, 1, 32'h3C, 32'h40);
        add(0, 1, 0, 0, 32'h0, 1, 32'h40, 32'h44);
        // Redirect during BOOT and during HALTED.
        add_boot(1'b1, 1'b1, 32'h100, 32'h100);
        add(0, 1, 0, 0, 32'h0, 1, 32'h100, 32'h104);
        add(0, 0, 1, 0, 32'h0, 1, 32'h100, 32'h104);
        add(0, 0, 1, 1, 32'h200, 0, 32'h100, 32'h200);
        add(0, 1, 0, 0, 32'h0, 0, 32'h100, 32'h200);
        add(0, 1, 0, 0, 32'h0, 1, 32'h200, 32'h204);

        foreach (tbl[i]) begin
            if (tbl[i].rst) apply_reset();
            Out_Ready = tbl[i].rdy;
            Halt      = tbl[i].halt;
            Rv        = tbl[i].rv;
            Rt        = tbl[i].rt;
            @(posedge Clk);
            #1;
            chk($sformatf("row%0d valid", i), 32'(ov0), 32'(tbl[i].ev));
            chk($sformatf("row%0d out_pc", i), opc0, tbl[i].epc);
            chk($sformatf("row%0d out_inst", i), oi0, tbl[i].einst);
            chk($sformatf("row%0d addr", i), addr0, tbl[i].eaddr);
        end

        // RESET_PC variants: 4,8,12 and the 32-bit wrap FFFFFFF8, FFFFFFFC, 0.
        Out_Ready = 1'b1; Halt = 1'b0; Rv = 1'b0; Rt = 32'h0;
        apply_reset();
        @(posedge Clk); #1;
        chk("v1 boot valid", 32'(ov1), 32'h0);
        chk("v1 boot addr",  addr1,    32'h0000_0004);
        chk("v2 boot valid", 32'(ov2), 32'h0);
        chk("v2 boot addr",  addr2,    32'hFFFF_FFF8);
        @(posedge Clk); #1;
        chk("v1 pc0", opc1, 32'h0000_0004);
        chk("v1 val0", 32'(ov1), 32'h1);
        chk("v2 pc0", opc2, 32'hFFFF_FFF8);
        chk("v2 inst0", oi2, rom(32'hFFFF_FFF8));
        @(posedge Clk); #1;
        chk("v1 pc1", opc1, 32'h0000_0008);
        chk("v2 pc1", opc2, 32'hFFFF_FFFC);
        @(posedge Clk); #1;
        chk("v1 pc2", opc1, 32'h0000_000C);
        chk("v2 pc2", opc2, 32'h0000_0000);
        chk("v2 val2", 32'(ov2), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
